// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side burst controller.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int ADDR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer of {last, data} beats sitting between the FIFO read port
// and the consumer stream; head entry is presented directly from registers.
module fifo_out_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_push_last,
  input  logic             i_pop,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_head_last
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_headData;
  logic             r_headLast;
  logic [WIDTH-1:0] r_tailData;
  logic             r_tailLast;

  // Push goes to the head when it is (or is about to be) free, otherwise to the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_headData <= '0;
      r_headLast <= 1'b0;
      r_tailData <= '0;
      r_tailLast <= 1'b0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_headData <= i_push_data;
            r_headLast <= i_push_last;
          end else begin
            r_tailData <= i_push_data;
            r_tailLast <= i_push_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_headData <= r_tailData;
            r_headLast <= r_tailLast;
          end
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_headData <= i_push_data;
            r_headLast <= i_push_last;
          end else begin
            r_headData <= r_tailData;
            r_headLast <= r_tailLast;
            r_tailData <= i_push_data;
            r_tailLast <= i_push_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_headData;
  assign o_head_last = r_headLast;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: waits for a full burst (or a flush), pops it through the
// FIFO's one-cycle-latency read port and streams it out with a last-beat marker.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_fifo_empty,
  input  logic [$clog2(DEPTH):0]     i_data_count,
  input  logic [WIDTH-1:0]           i_fifo_rdData,
  output logic                       o_fifo_rdEn,
  input  logic                       i_flush,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_out_data,
  output logic                       o_out_last,
  output logic                       o_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_delivered;
  logic          r_inflight;
  logic          r_inflightLast;

  logic [1:0]    w_occ;
  logic [2:0]    w_level;
  logic          w_pop;
  logic          w_start;
  logic          w_rdEn;
  logic          w_lastIssue;
  logic          w_lastPop;

  assign w_pop       = o_out_valid && i_out_ready;
  assign w_start     = (i_data_count >= BURST_C) || (i_flush && !i_fifo_empty);
  assign w_level     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rdEn      = (r_state == READ) && (r_issued < r_len) && !i_fifo_empty
                       && (w_level < 3'd2);
  assign w_lastIssue = (r_issued == r_len - CW'(1));
  assign w_lastPop   = w_pop && (r_delivered == r_len - CW'(1));

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_start) w_stateNext = READ;
      READ:    if (w_rdEn && w_lastIssue) w_stateNext = DRAIN;
      DRAIN:   if (w_lastPop) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Burst length is frozen at start; a short burst only happens on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_issued       <= '0;
      r_delivered    <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_inflight <= w_rdEn;
      if (w_rdEn) r_inflightLast <= w_lastIssue;
      if (r_state == IDLE && w_start) begin
        r_len       <= (i_data_count >= BURST_C) ? BURST_C : i_data_count;
        r_issued    <= '0;
        r_delivered <= '0;
      end else begin
        if (w_rdEn) r_issued    <= r_issued + CW'(1);
        if (w_pop)  r_delivered <= r_delivered + CW'(1);
      end
    end
  end

  fifo_out_skid #(.WIDTH(WIDTH)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_rdData),
    .i_push_last (r_inflightLast),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (o_out_data),
    .o_head_last (o_out_last)
  );

  assign o_fifo_rdEn = w_rdEn;
  assign o_out_valid = (w_occ != 2'd0);
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and a
// burst-level scoreboard predicts every beat, its last flag, busy and valid.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int CW    = CNT_W;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_fifo_empty;
  logic [CW-1:0]    i_data_count;
  logic [WIDTH-1:0] i_fifo_rdData;
  logic             i_flush;
  logic             i_out_ready;
  logic             sel;

  logic             rdEn4, valid4, last4, busy4;
  logic [WIDTH-1:0] data4;
  logic             rdEn1, valid1, last1, busy1;
  logic [WIDTH-1:0] data1;
  logic             obsRdEn, obsValid, obsLast, obsBusy;
  logic [WIDTH-1:0] obsData;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH), .BURST(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_fifo_empty(i_fifo_empty), .i_data_count(i_data_count),
    .i_fifo_rdData(i_fifo_rdData), .o_fifo_rdEn(rdEn4), .i_flush(i_flush),
    .o_out_valid(valid4), .i_out_ready(i_out_ready), .o_out_data(data4),
    .o_out_last(last4), .o_busy(busy4)
  );

  fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH), .BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_fifo_empty(i_fifo_empty), .i_data_count(i_data_count),
    .i_fifo_rdData(i_fifo_rdData), .o_fifo_rdEn(rdEn1), .i_flush(i_flush),
    .o_out_valid(valid1), .i_out_ready(i_out_ready), .o_out_data(data1),
    .o_out_last(last1), .o_busy(busy1)
  );

  assign obsRdEn  = sel ? rdEn1  : rdEn4;
  assign obsValid = sel ? valid1 : valid4;
  assign obsLast  = sel ? last1  : last4;
  assign obsBusy  = sel ? busy1  : busy4;
  assign obsData  = sel ? data1  : data4;

  logic [WIDTH-1:0] fifoQ[$];
  beat_t            expQ[$];
  int  checks = 0, errors = 0;
  bit  modelBusy, startedPrev, rdPrev1, pendRd, holdEmpty, afterReset, busyPrev;
  int  readTotal, popTotal, cycle;
  int  tBeats, tLasts, tReads, tFirstRd, tLastRd, tBusyRises;
  int  patIdx;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic updateFlags();
    i_data_count = CW'(fifoQ.size());
    i_fifo_empty = holdEmpty || (fifoQ.size() == 0);
  endtask

  task automatic writeWord(input logic [WIDTH-1:0] w);
    fifoQ.push_back(w);
    updateFlags();
  endtask

  function automatic int burstLen();
    return sel ? 1 : 4;
  endfunction

  // Mid-cycle observation: score this cycle, then advance the burst-level model.
  task automatic modelObserve();
    bit hs, lastNow, startedNow;
    int len;
    beat_t b;
    hs = obsValid && i_out_ready;
    lastNow = 0;
    startedNow = 0;
    if (afterReset) begin
      checkOutput("rstValid", obsValid, 0);
      checkOutput("rstLast", obsLast, 0);
      checkOutput("rstData", obsData, 0);
      checkOutput("rstRdEn", obsRdEn, 0);
      checkOutput("rstBusy", obsBusy, 0);
      afterReset = 0;
    end
    checkOutput("rdWhileEmpty", obsRdEn && i_fifo_empty, 0);
    checkOutput("busy", obsBusy, modelBusy);
    if (!modelBusy) checkOutput("idleRd", obsRdEn, 0);
    if (startedPrev && !i_fifo_empty) checkOutput("firstRdLatency", obsRdEn, 1);
    checkOutput("outValid", obsValid, (readTotal - int'(rdPrev1) - popTotal) > 0);
    if (hs) begin
      checkOutput("beatExpected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        b = expQ.pop_front();
        checkOutput("outData", obsData, b.d);
        checkOutput("outLast", obsLast, b.l);
        tBeats++;
        if (b.l) begin
          tLasts++;
          lastNow = 1;
        end
      end
      popTotal++;
    end
    if (obsRdEn) begin
      readTotal++;
      tReads++;
      if (tReads == 1) tFirstRd = cycle;
      tLastRd = cycle;
    end
    checkOutput("bufLevel", (readTotal - popTotal) <= 2, 1);
    if (!modelBusy && (fifoQ.size() >= burstLen() || (i_flush && !i_fifo_empty))) begin
      len = (fifoQ.size() >= burstLen()) ? burstLen() : fifoQ.size();
      for (int i = 0; i < len; i++) expQ.push_back('{fifoQ[i], i == len - 1});
      modelBusy  = 1;
      startedNow = 1;
    end
    if (lastNow) modelBusy = 0;
    if (obsBusy && !busyPrev) tBusyRises++;
    busyPrev    = obsBusy;
    rdPrev1     = obsRdEn;
    startedPrev = startedNow;
    pendRd      = obsRdEn;
  endtask

  task automatic applyStimulus(input logic ready);
    i_out_ready = ready;
    @(negedge clk);
    if (reset) pendRd = 0;
    else modelObserve();
    cycle++;
    @(posedge clk);
    #1;
    if (reset) begin
      fifoQ.delete();
      expQ.delete();
      modelBusy = 0; startedPrev = 0; rdPrev1 = 0; pendRd = 0; busyPrev = 0;
      readTotal = 0; popTotal = 0; afterReset = 1;
    end
    if (pendRd && fifoQ.size() > 0) i_fifo_rdData = fifoQ.pop_front();
    else i_fifo_rdData = WIDTH'($urandom);
    updateFlags();
  endtask

  task automatic startTest(input string name);
    $display("[TB] test: %s", name);
    tBeats = 0; tLasts = 0; tReads = 0; tFirstRd = -1; tLastRd = -1; tBusyRises = 0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random ready
  task automatic runDrain(input int bound, input int mode);
    bit done;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      case (mode)
        0: applyStimulus(1'b1);
        1: begin applyStimulus(pat[patIdx % 4]); patIdx++; end
        default: applyStimulus(1'($urandom_range(0, 1)));
      endcase
      done = !modelBusy && fifoQ.size() == 0 && expQ.size() == 0;
    end
    checkOutput("drainTimeout", done, 1);
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_flush = 1'b0; i_out_ready = 1'b0; sel = 1'b0;
    holdEmpty = 0; cycle = 0; patIdx = 0; i_fifo_rdData = '0;
    updateFlags();
    doReset(2);

    startTest("full burst A1..A4");
    for (int i = 1; i <= 4; i++) writeWord(WIDTH'(8'hA0 + i));
    runDrain(40, 0);
    checkOutput("t1Beats", tBeats, 4);
    checkOutput("t1Lasts", tLasts, 1);
    checkOutput("t1Reads", tReads, 4);
    checkOutput("t1ReadSpan", tLastRd - tFirstRd, 3);

    startTest("short burst needs flush");
    for (int i = 1; i <= 3; i++) writeWord(WIDTH'(8'hB0 + i));
    for (int i = 0; i < 20; i++) applyStimulus(1'b1);
    checkOutput("t2NoReads", tReads, 0);
    i_flush = 1'b1;
    applyStimulus(1'b1);
    i_flush = 1'b0;
    runDrain(40, 0);
    checkOutput("t2Beats", tBeats, 3);
    checkOutput("t2Lasts", tLasts, 1);

    startTest("back-pressure pattern");
    for (int i = 0; i < 8; i++) writeWord(WIDTH'(8'hC0 + i));
    runDrain(100, 1);
    checkOutput("t3Beats", tBeats, 8);
    checkOutput("t3Lasts", tLasts, 2);

    startTest("fifo empty mid-burst");
    for (int i = 0; i < 4; i++) writeWord(WIDTH'(8'hD0 + i));
    for (int i = 0; i < 20 && tReads < 2; i++) applyStimulus(1'b1);
    checkOutput("t4ReadsBefore", tReads, 2);
    holdEmpty = 1; updateFlags();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    checkOutput("t4Stalled", tReads, 2);
    holdEmpty = 0; updateFlags();
    runDrain(40, 0);
    checkOutput("t4Beats", tBeats, 4);
    checkOutput("t4Lasts", tLasts, 1);

    startTest("reset during drain");
    writeWord(8'hE1); writeWord(8'hE2);
    i_flush = 1'b1;
    applyStimulus(1'b0);
    i_flush = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0);
    checkOutput("t5Buffered", readTotal - popTotal, 2);
    checkOutput("t5BusyBefore", obsBusy, 1);
    doReset(1);
    startTest("refill after reset");
    for (int i = 0; i < 4; i++) writeWord(WIDTH'(8'hF0 + i));
    runDrain(40, 0);
    checkOutput("t5Beats", tBeats, 4);
    checkOutput("t5Lasts", tLasts, 1);

    startTest("random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && fifoQ.size() < FIFO_DEPTH) writeWord(WIDTH'($urandom));
      i_flush = ($urandom_range(0, 9) == 0);
      applyStimulus(1'($urandom_range(0, 1)));
    end
    i_flush = 1'b1;
    runDrain(300, 2);
    i_flush = 1'b0;
    checkOutput("t6LastsPerBurst", tLasts == tBusyRises, 1);

    startTest("burst of one");
    sel = 1'b1;
    doReset(2);
    for (int i = 1; i <= 3; i++) writeWord(WIDTH'(8'h90 + i));
    runDrain(40, 0);
    checkOutput("t7Beats", tBeats, 3);
    checkOutput("t7Lasts", tLasts, 3);
    checkOutput("t7BusyPulses", tBusyRises, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller placed directly downstream of the synchronous FIFO. It waits until the FIFO holds a full burst, or until a flush is requested, then pops that burst through the FIFO's one-cycle-latency read port. Data is presented to a consumer on a valid/ready stream with a last-beat marker. A 2-entry output buffer lets back-pressure from the consumer stall reads without losing in-flight data, while still sustaining one beat per cycle.

## Interface
- width, 8, data word width; matches the FIFO.
- depth, 8, FIFO depth; sets data_count width to $clog2(depth)+1.
- burst, 4, beats per normal burst; legal range 1..depth.

- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- fifo_empty  in  1  FIFO empty flag.
- data_count  in  $clog2(depth)+1  FIFO occupancy.
- fifo_rdData  in  width  FIFO read data; valid exactly one cycle after fifo_rdEn.
- fifo_rdEn  out  1  pop request to FIFO.
- flush  in  1  level; permits a short burst of min(data_count, burst) when fewer than burst words are held.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat when out_valid && out_ready.
- out_data  out  width  beat payload.
- out_last  out  1  final beat of current burst; qualified by out_valid.
- busy  out  1  high whenever state != IDLE.

## Operation
- States:
  - IDLE: no reads issued. Moves to READ when data_count >= burst, or when flush && !fifo_empty. On entry to READ, latch len = (data_count >= burst) ? burst : data_count. Set issued = 0 and delivered = 0.
  - READ: issue reads; moves to DRAIN in the cycle the read with issued == len-1 is issued.
  - DRAIN: no reads issued; moves to IDLE in the cycle the beat with delivered == len-1 is accepted (out_last handshake).
- Read issue rule: fifo_rdEn = (state == READ) && issued < len && !fifo_empty && (occ + inflight - pop) < 2.
  - occ: output-buffer entries, 0..2.
  - inflight: the previous cycle's fifo_rdEn, 0..1.
  - pop = out_valid && out_ready.
- Capture: when inflight == 1, fifo_rdData is written into the output buffer in that cycle. The buffer never overflows under the issue rule.
- Output: out_valid = (occ != 0); out_data and out_last come from the buffer head. out_last is stored per entry, set on the entry whose beat index == len-1.
- Counters issued and delivered have width $clog2(depth)+1 and never wrap, since len <= depth.
- flush is sampled only in IDLE. It is ignored during READ and DRAIN.
- Simultaneous capture and pop in one cycle: occ is unchanged, head advances, new entry goes to tail.
- burst == 1: every burst is a single beat with out_last = 1.
- Reset mid-burst: state goes to IDLE, the buffer is emptied, and the in-flight read is dropped. The FIFO shares the reset, so no words are orphaned.

## Timing
- Reset values: fifo_rdEn = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
- Start condition true in IDLE at cycle N:
  - busy = 1 and first fifo_rdEn in cycle N+1 (if !fifo_empty).
  - Data captured at the end of N+2.
  - out_valid = 1 in N+3.
- With out_ready held high and the FIFO non-empty, one beat per cycle: len beats occupy cycles N+3 .. N+2+len.
- The IDLE re-entry cycle follows the out_last handshake. The next start can be evaluated in that same IDLE cycle.
- Back-pressure: with out_ready low, at most 2 beats are buffered and no read is issued while occ + inflight == 2.
- out_valid, out_data and out_last are registered outputs. fifo_rdEn is combinational from registered state plus fifo_empty and out_ready.

## Structure
- Shared package fifo_pkg:
  - state enum {IDLE, READ, DRAIN}.
  - Width constants CNT_W = $clog2(depth)+1 and ADDR_W = $clog2(depth).
  - Shared with the FIFO for the data_count width.
- Sub-module fifo_out_skid: 2-entry buffer holding {last, data}.
  - Ports: push, push_data, push_last, pop, occ, head_data, head_last.
  - Contains only buffering; all burst control stays in fifo_burst_reader.

## Test plan
- Preload FIFO with 4 words (0xA1..0xA4), burst=4, out_ready=1 → reads in consecutive cycles; out_valid from N+3 for 4 cycles; data A1..A4; out_last only on A4; busy falls the cycle after.
- FIFO holds 3 words, flush=0 → no fifo_rdEn for 20 cycles. Assert flush=1 → len=3, out_last on the third beat.
- 8 words, out_ready toggled 1,0,0,1,… → no beat lost or duplicated; occ never exceeds 2; order preserved; two bursts of 4 each with out_last on beats 4 and 8.
- FIFO empties mid-burst (writer paused after 2 of 4) → fifo_rdEn drops while fifo_empty=1; reads resume when the writer adds words; burst completes with 4 beats.
- Assert reset during DRAIN with 2 beats buffered → next cycle out_valid=0, busy=0, fifo_rdEn=0; after refill, the next burst starts cleanly.
- burst=1, depth=8, 3 words → three single-beat bursts, each with out_last=1 and busy pulsing per beat.
